dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 44 ++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e            : arbiter FSM states
//   F3_*               : RV32I load/store func3 encodings
//   MEM_BYTES_DEFAULT  : default data-memory depth in bytes
//   access_size()      : bytes touched by a func3 (1, 2 or 4)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_BYTES_DEFAULT = 41;

  // Size comes from func3[1:0]; signedness bit [2] does not affect width.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer -> port 0)
//   en_i     : grant allowed this cycle; pointer only advances on a grant
//   req_i    : per-port request
//   gnt_o    : one-hot grant (combinational), zero when en_i is low
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the port that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // Pointer always moves to the port that did not win.
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters (0 = core LSU, 1 = loader/debug) onto a single
// data-memory port. Each access runs IDLE -> ACCESS -> RESP -> IDLE.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid/ready/we/addr/func3/wdata : per-port request (port 1 in upper half)
//   rsp_valid     : one-cycle response pulse to the owning port
//   rsp_rdata/err : shared response data / access-fault flag, held until next RESP
//   mem_*         : data-memory interface; mem_loadVal is combinational read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [5:0]  req_func3,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_writeEn,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_storeVal,
  input  logic [31:0] mem_loadVal
);

  state_e      state_q;
  logic        owner_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  func3_q;
  logic [31:0] wdata_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [1:0]  gnt;
  logic        grant_en;
  logic        sel;

  // Grants only in IDLE and never while reset is asserted.
  assign grant_en = (state_q == IDLE) && !rst;
  assign sel      = gnt[1];

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en_i  (grant_en),
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  // Legality of the captured request.
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        f3_ok, align_ok, range_ok, legal;

  always_comb begin
    size = access_size(func3_q);
    if (we_q) begin
      f3_ok = func3_q inside {F3_B, F3_H, F3_W};
    end else begin
      f3_ok = func3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end
    case (func3_q[1:0])
      2'b01:   align_ok = ~addr_q[0];
      2'b10:   align_ok = (addr_q[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    // 33 bits so that an address near 2^32 cannot wrap back into range.
    end_addr = {1'b0, addr_q} + {30'd0, size};
    range_ok = (end_addr <= 33'(MEM_BYTES));
    legal    = f3_ok && align_ok && range_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      func3_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q <= sel;
            we_q    <= sel ? req_we[1]         : req_we[0];
            addr_q  <= sel ? req_addr[63:32]   : req_addr[31:0];
            func3_q <= sel ? req_func3[5:3]    : req_func3[2:0];
            wdata_q <= sel ? req_wdata[63:32]  : req_wdata[31:0];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          if (!legal) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else if (we_q) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end else begin
            rsp_rdata_q <= mem_loadVal;
            rsp_err_q   <= 1'b0;
          end
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write strobe is qualified by !rst so a reset landing on ACCESS suppresses the store.
  assign mem_writeEn  = (state_q == ACCESS) && we_q && legal && !rst;
  assign mem_addr     = addr_q;
  assign mem_func3    = func3_q;
  assign mem_storeVal = wdata_q;

  assign rsp_valid = rsp_valid_q & {2{~rst}};
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
